rm_lane_reclaimer: RTL and testbench
====================================

RM_LANE_RECLAIMER -- requirements
Module: rm_lane_reclaimer

Interface
REQ-001 SHALL have parameter NUM_LANES, default ariane_pkg::RM_NUM_LANES, number of runtime-monitor lanes.
REQ-002 SHALL have parameter NUM_EVENTS, default ariane_pkg::RM_NUM_EVENTS, number of pipeline event sources per lane.
REQ-003 SHALL have parameter TIMEOUT, default 1024, active cycles before a lane is forcibly reclaimed.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, clock; rst_ni input 1, async active-low reset.
REQ-005 SHALL have flush_i input 1: pipeline flush.
REQ-006 SHALL have lane_alloc_i input ariane_pkg::lane_ctrl (NUM_LANES bits): lanes granted by the allocator this cycle.
REQ-007 SHALL have event_i input lane_ctrl[NUM_EVENTS]: per-event lane mask from the stage event detectors.
REQ-008 SHALL have reset_monitor_o output lane_ctrl[NUM_EVENTS]: per-event lane-release mask to the allocator.
REQ-009 SHALL have lane_free_o output NUM_LANES: lane is IDLE.
REQ-010 SHALL have lat_valid_o output NUM_LANES: one-cycle pulse, lane latency report valid.
REQ-011 SHALL have lat_cycles_o output NUM_LANES x 16: alloc-to-release cycle count per lane.
REQ-012 SHALL have timeout_o output NUM_LANES: one-cycle pulse, lane was reclaimed by timeout.
REQ-013 SHALL have proto_err_o output 1: sticky, set on allocation of a non-IDLE lane.

Function
REQ-014 SHALL run one FSM per lane with states IDLE, ACTIVE and RELEASE.
REQ-015 IDLE->ACTIVE SHALL occur when lane_alloc_i[l]=1 and flush_i=0; seen mask and counter clear to 0 on entry.
REQ-016 In ACTIVE, seen[e] SHALL be set when event_i[e][l]=1; events in the alloc cycle count.
REQ-017 ACTIVE->RELEASE SHALL occur when (seen | current events) covers all NUM_EVENTS bits.
REQ-018 ACTIVE->RELEASE SHALL also occur when the counter reaches TIMEOUT-1 with the lane incomplete; timeout_o[l] pulses during RELEASE.
REQ-019 flush_i SHALL move every ACTIVE lane to RELEASE and SHALL suppress all allocations that cycle.
REQ-020 In RELEASE, reset_monitor_o[e][l]=1 for all e and lat_valid_o[l]=1 SHALL hold for exactly one cycle; the next state is IDLE unconditionally.
REQ-021 Completion latency SHALL be: last event at cycle N -> RELEASE at N+1 -> IDLE with lane_free_o[l]=1 at N+2.
REQ-022 The counter SHALL increment every ACTIVE cycle, saturate at 16'hFFFF, and be held stable on lat_cycles_o until the next allocation.
REQ-023 Events for IDLE or RELEASE lanes SHALL be ignored.
REQ-024 An allocation of an ACTIVE or RELEASE lane SHALL be ignored and SHALL set proto_err_o.
REQ-025 Completion, timeout and flush in the same cycle SHALL yield one RELEASE; timeout_o is set only if incomplete and not flushed.
REQ-026 Lanes SHALL be fully independent; any number may release in the same cycle.

Reset
REQ-027 On rst_ni=0, all lanes SHALL go to IDLE, with seen, counters and proto_err_o at 0, lane_free_o all 1, and all other outputs 0.
REQ-028 Reset asserted mid-ACTIVE SHALL abort the lane with no RELEASE pulse.

Structure
REQ-029 ariane_pkg SHALL hold RM_NUM_LANES, RM_NUM_EVENTS, the lane_ctrl typedef and a new rm_lane_state_e enum.
REQ-030 The per-lane FSM, seen mask and counter SHALL be sub-module rm_lane_tracker, instantiated NUM_LANES times; the top level does only bit slicing and proto_err_o.

Verification
REQ-031 Alloc lane 0 at cycle 0; events 0..3 at cycles 2..5 -> reset_monitor_o[*][0]=1 at cycle 6, lat_cycles_o[0]=6, lane_free_o[0]=1 at cycle 7.
REQ-032 Alloc lane 1 with no events, TIMEOUT=16 -> timeout_o[1] and reset_monitor pulse at cycle 16, lat_cycles_o[1]=16.
REQ-033 Lanes 0-3 ACTIVE, flush_i=1 together with lane_alloc_i=4'b0001 -> all four release next cycle, no new allocation, timeout_o=0.
REQ-034 Re-allocate ACTIVE lane 2 -> proto_err_o=1 sticky, lane 2 state and counter unchanged.
REQ-035 Lanes 0 and 3 complete in the same cycle -> both reset_monitor columns and lat_valid_o bits pulse simultaneously.
REQ-036 Assert rst_ni low while lane 0 is ACTIVE -> outputs at reset values immediately, with no reset_monitor pulse afterward.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared runtime-monitor sizing, lane mask type and per-lane reclaim state.
package ariane_pkg;
  localparam int unsigned RM_NUM_LANES  = 4;
  localparam int unsigned RM_NUM_EVENTS = 4;

  typedef logic [RM_NUM_LANES-1:0] lane_ctrl;

  typedef enum logic [1:0] {
    RM_IDLE    = 2'd0,
    RM_ACTIVE  = 2'd1,
    RM_RELEASE = 2'd2
  } rm_lane_state_e;
endpackage

// File: rtl/rm_lane_tracker.sv
// One monitor lane: tracks which events have been seen since allocation,
// counts active cycles, and releases on completion, timeout or flush.
module rm_lane_tracker
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = RM_NUM_EVENTS,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  free_o,
  output logic                  release_o,
  output logic                  timeout_o,
  output logic [15:0]           lat_cycles_o,
  output logic                  alloc_err_o
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  rm_lane_state_e        state_q, state_d;
  logic [NUM_EVENTS-1:0] seen_q, seen_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  to_q, to_d;
  logic                  complete;

  assign complete = &(seen_q | event_i);

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      RM_IDLE: begin
        if (alloc_i && !flush_i) begin
          state_d = RM_ACTIVE;
          seen_d  = event_i;  // events arriving with the grant already count
          cnt_d   = '0;
        end
      end
      RM_ACTIVE: begin
        seen_d = seen_q | event_i;
        cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (flush_i || complete) begin
          state_d = RM_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          state_d = RM_RELEASE;
          to_d    = 1'b1;
        end
      end
      RM_RELEASE: state_d = RM_IDLE;
      default:    state_d = RM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RM_IDLE;
      seen_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign free_o       = (state_q == RM_IDLE);
  assign release_o    = (state_q == RM_RELEASE);
  assign timeout_o    = to_q;
  assign lat_cycles_o = cnt_q;
  assign alloc_err_o  = alloc_i && !flush_i && (state_q != RM_IDLE);
endmodule

// File: rtl/rm_lane_reclaimer.sv
// Per-lane reclaim trackers plus event/release mask transposition and a
// sticky protocol error for grants to lanes that are still busy.
module rm_lane_reclaimer
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_LANES  = RM_NUM_LANES,
  parameter int unsigned NUM_EVENTS = RM_NUM_EVENTS,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NUM_LANES-1:0]                 lane_alloc_i,
  input  logic [NUM_EVENTS-1:0][NUM_LANES-1:0] event_i,
  output logic [NUM_EVENTS-1:0][NUM_LANES-1:0] reset_monitor_o,
  output logic [NUM_LANES-1:0]                 lane_free_o,
  output logic [NUM_LANES-1:0]                 lat_valid_o,
  output logic [NUM_LANES-1:0][15:0]           lat_cycles_o,
  output logic [NUM_LANES-1:0]                 timeout_o,
  output logic                                 proto_err_o
);
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] lane_ev;
  logic [NUM_LANES-1:0]                 rel;
  logic [NUM_LANES-1:0]                 alloc_err;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_ev
      assign lane_ev[l][e]         = event_i[e][l];
      assign reset_monitor_o[e][l] = rel[l];
    end

    rm_lane_tracker #(
      .NUM_EVENTS(NUM_EVENTS),
      .TIMEOUT   (TIMEOUT)
    ) u_trk (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .alloc_i     (lane_alloc_i[l]),
      .event_i     (lane_ev[l]),
      .free_o      (lane_free_o[l]),
      .release_o   (rel[l]),
      .timeout_o   (timeout_o[l]),
      .lat_cycles_o(lat_cycles_o[l]),
      .alloc_err_o (alloc_err[l])
    );
  end

  assign lat_valid_o = rel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         proto_err_o <= 1'b0;
    else if (|alloc_err) proto_err_o <= 1'b1;
  end
endmodule

// File: tb/tb_rm_lane_reclaimer.sv
// Scoreboard bench: each scenario queues the releases it expects; a negedge
// monitor matches every lat_valid pulse against the queue.
module tb_rm_lane_reclaimer;
  localparam int NL = 4;
  localparam int NE = 4;
  localparam int TO = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   flush_i = 1'b0;
  logic [NL-1:0]          lane_alloc_i = '0;
  logic [NE-1:0][NL-1:0]  event_i = '0;
  logic [NE-1:0][NL-1:0]  reset_monitor_o;
  logic [NL-1:0]          lane_free_o;
  logic [NL-1:0]          lat_valid_o;
  logic [NL-1:0][15:0]    lat_cycles_o;
  logic [NL-1:0]          timeout_o;
  logic                   proto_err_o;

  rm_lane_reclaimer #(.NUM_LANES(NL), .NUM_EVENTS(NE), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .lane_alloc_i(lane_alloc_i), .event_i(event_i),
    .reset_monitor_o(reset_monitor_o), .lane_free_o(lane_free_o),
    .lat_valid_o(lat_valid_o), .lat_cycles_o(lat_cycles_o),
    .timeout_o(timeout_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int lane; int lat; bit to; int cyc;} exp_t;
  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(int lane, int lat, bit to, int c);
    exp_t x;
    x.lane = lane; x.lat = lat; x.to = to; x.cyc = c;
    sbq.push_back(x);
  endtask

  // Release monitor
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int l = 0; l < NL; l++) begin
        logic [NE-1:0] col;
        for (int e = 0; e < NE; e++) col[e] = reset_monitor_o[e][l];
        if (lat_valid_o[l]) begin
          int idx = -1;
          for (int i = 0; i < sbq.size(); i++)
            if (idx < 0 && sbq[i].lane == l) idx = i;
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_release lane=%0d cyc=%0d got lat_valid=1 want 0", l, cyc);
          end else begin
            checks++;
            if (cyc !== sbq[idx].cyc || lat_cycles_o[l] !== 16'(sbq[idx].lat) ||
                timeout_o[l] !== sbq[idx].to || col !== {NE{1'b1}}) begin
              failures++;
              $display("FAIL release lane=%0d got cyc=%0d lat=%0d to=%0b col=%b want cyc=%0d lat=%0d to=%0b col=%b",
                       l, cyc, lat_cycles_o[l], timeout_o[l], col,
                       sbq[idx].cyc, sbq[idx].lat, sbq[idx].to, {NE{1'b1}});
            end
            sbq.delete(idx);
          end
        end else begin
          checks++;
          if (col !== '0 || timeout_o[l] !== 1'b0) begin
            failures++;
            $display("FAIL idle_pulse lane=%0d cyc=%0d got col=%b to=%0b want 0", l, cyc, col, timeout_o[l]);
          end
        end
      end
    end
  end

  task automatic check_drained(string name);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_release got pending=%0d want 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    lane_alloc_i = '0; event_i = '0; flush_i = 1'b0;
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (lane_free_o !== '1 || lat_valid_o !== '0 || timeout_o !== '0 ||
        reset_monitor_o !== '0 || lat_cycles_o !== '0 || proto_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset got free=%b vld=%b to=%b rm=%h lat=%h perr=%b want free=1111 rest 0",
               lane_free_o, lat_valid_o, timeout_o, reset_monitor_o, lat_cycles_o, proto_err_o);
    end
  endtask

  task automatic test_complete();
    int base;
    do_reset();
    lane_alloc_i = 4'b0001;
    tick(); lane_alloc_i = '0; base = cyc;
    push(0, 6, 1'b0, base + 6);
    checks++;
    if (lane_free_o[0] !== 1'b0) begin
      failures++; $display("FAIL complete_busy got free=%b want 0", lane_free_o[0]);
    end
    tick();
    for (int e = 0; e < NE; e++) begin
      tick(); event_i = '0; event_i[e][0] = 1'b1;
    end
    tick(); event_i = '0;
    checks++;
    if (lane_free_o[0] !== 1'b0) begin
      failures++; $display("FAIL complete_release_busy got free=%b want 0", lane_free_o[0]);
    end
    tick();
    checks++;
    if (lane_free_o[0] !== 1'b1 || lat_cycles_o[0] !== 16'd6) begin
      failures++;
      $display("FAIL complete_idle got free=%b lat=%0d want free=1 lat=6", lane_free_o[0], lat_cycles_o[0]);
    end
    tick(); tick();
    checks++;
    if (lat_cycles_o[0] !== 16'd6) begin
      failures++; $display("FAIL complete_hold got lat=%0d want 6", lat_cycles_o[0]);
    end
    check_drained("complete");
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    lane_alloc_i = 4'b0010;
    tick(); lane_alloc_i = '0; base = cyc;
    push(1, TO, 1'b1, base + TO);
    repeat (TO + 1) tick();
    checks++;
    if (lane_free_o[1] !== 1'b1 || lat_cycles_o[1] !== 16'(TO)) begin
      failures++;
      $display("FAIL timeout_idle got free=%b lat=%0d want free=1 lat=%0d", lane_free_o[1], lat_cycles_o[1], TO);
    end
    check_drained("timeout");
  endtask

  task automatic test_flush();
    int base;
    do_reset();
    lane_alloc_i = 4'b1111;
    tick(); lane_alloc_i = '0; base = cyc;
    tick(); tick();
    flush_i = 1'b1; lane_alloc_i = 4'b0001;
    for (int l = 0; l < NL; l++) push(l, 3, 1'b0, base + 3);
    tick(); flush_i = 1'b0; lane_alloc_i = '0;
    tick();
    checks++;
    if (lane_free_o !== 4'b1111) begin
      failures++; $display("FAIL flush_free got %b want 1111", lane_free_o);
    end
    tick();
    check_drained("flush");
  endtask

  task automatic test_proto_err();
    do_reset();
    lane_alloc_i = 4'b0100;
    tick(); lane_alloc_i = '0;
    checks++;
    if (proto_err_o !== 1'b0) begin
      failures++; $display("FAIL proto_clean got %b want 0", proto_err_o);
    end
    tick(); tick();
    lane_alloc_i = 4'b0100;
    tick(); lane_alloc_i = '0;
    checks++;
    if (proto_err_o !== 1'b1 || lane_free_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL proto_set got perr=%b free2=%b want perr=1 free2=0", proto_err_o, lane_free_o[2]);
    end
    for (int e = 0; e < NE; e++) event_i[e][2] = 1'b1;
    push(2, 4, 1'b0, cyc + 1);
    tick(); event_i = '0;
    tick(); tick();
    checks++;
    if (proto_err_o !== 1'b1) begin
      failures++; $display("FAIL proto_sticky got %b want 1", proto_err_o);
    end
    check_drained("proto");
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    lane_alloc_i = 4'b1001;
    tick(); lane_alloc_i = '0; base = cyc;
    tick();
    for (int e = 0; e < NE; e++) begin
      event_i[e][0] = 1'b1; event_i[e][3] = 1'b1;
    end
    push(0, 2, 1'b0, base + 2);
    push(3, 2, 1'b0, base + 2);
    tick(); event_i = '0;
    tick(); tick();
    // lane 0 straight back into service after release
    lane_alloc_i = 4'b0001;
    event_i[0][0] = 1'b1; event_i[1][0] = 1'b1;
    tick(); lane_alloc_i = '0; base = cyc;
    event_i = '0; event_i[2][0] = 1'b1; event_i[3][0] = 1'b1;
    push(0, 1, 1'b0, base + 1);
    tick(); event_i = '0;
    tick(); tick();
    check_drained("back_to_back");
  endtask

  task automatic test_reset_abort();
    do_reset();
    lane_alloc_i = 4'b0001;
    tick(); lane_alloc_i = '0;
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (lane_free_o !== '1 || lat_valid_o !== '0 || reset_monitor_o !== '0 || lat_cycles_o !== '0) begin
      failures++;
      $display("FAIL reset_abort got free=%b vld=%b rm=%h lat=%h want free=1111 rest 0",
               lane_free_o, lat_valid_o, reset_monitor_o, lat_cycles_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    repeat (TO + 4) tick();
    checks++;
    if (lane_free_o !== '1) begin
      failures++; $display("FAIL reset_abort_idle got free=%b want 1111", lane_free_o);
    end
    check_drained("reset_abort");
  endtask

  initial begin
    test_reset();
    test_complete();
    test_timeout();
    test_flush();
    test_proto_err();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end
endmodule
